// File: rtl/calc_job_dispatcher.sv
// Operand FIFO plus start/busy sequencer feeding the square-plus-cube-root unit.
// Results come back out on a valid/ready port, strictly in submission order.
module calc_job_dispatcher #(
    parameter int DEPTH = 4,
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int R_W   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [A_W-1:0]         in_a_i,
    input  logic [B_W-1:0]         in_b_i,
    output logic                   start_o,
    output logic [A_W-1:0]         a_bo,
    output logic [B_W-1:0]         b_bo,
    input  logic                   busy_i,
    input  logic [R_W-1:0]         result_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [R_W-1:0]         out_result_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [A_W+B_W-1:0] mem [DEPTH];
    logic [1:0]         wait_cnt;
    logic               push, pop, capture, out_free;

    assign in_ready_o = (count_o != CNT_W'(DEPTH));
    assign push       = in_valid_i && in_ready_o;
    // The output slot counts as free in the cycle its handshake completes.
    assign out_free   = !out_valid_o || out_ready_i;
    assign start_o    = (state == ISSUE);

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (count_o != '0 && !busy_i && out_free) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy_i)                state_next = WAIT_DONE;
                else if (wait_cnt == 2'd3) state_next = ISSUE;
            end
            WAIT_DONE: begin
                if (!busy_i) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: storage is not reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {in_a_i, in_b_i};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_o      <= '0;
            wait_cnt     <= '0;
            a_bo         <= '0;
            b_bo         <= '0;
            out_valid_o  <= 1'b0;
            out_result_o <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                {a_bo, b_bo} <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
            // Watchdog: counts idle cycles after a start the unit failed to pick up.
            if (state != WAIT_BUSY)  wait_cnt <= '0;
            else if (!busy_i)        wait_cnt <= wait_cnt + 2'd1;
            if (capture) begin
                out_valid_o  <= 1'b1;
                out_result_o <= result_i;
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_job_dispatcher.sv
// Scoreboard bench for calc_job_dispatcher with a behavioural compute-unit model.
// The model answers a*a + floor(cbrt(b)) after a programmable busy period.
module tb_calc_job_dispatcher;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0, in_b = '0;
    logic        start_o;
    logic [7:0]  a_bo, b_bo;
    logic        busy = 1'b0;
    logic [15:0] result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [2:0]  count_o;

    int vectors = 0, errors = 0;
    logic [15:0] exp_q[$];

    // compute-unit model controls and monitor state
    bit   force_busy = 0;
    int   model_lat = 20, model_ignore = 0, busy_cnt = 0;
    logic [15:0] pending = '0;
    int   starts = 0, valid_cycles = 0, cyc = 0, max_count = 0;
    int   last_start_cyc = 0, prev_start_cyc = 0;
    logic [7:0] last_a = '0, last_b = '0, prev_a = '0, prev_b = '0;

    calc_job_dispatcher #(.DEPTH(4), .A_W(8), .B_W(8), .R_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
        .start_o(start_o), .a_bo(a_bo), .b_bo(b_bo), .busy_i(busy), .result_i(result),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] calc(input logic [7:0] a, input logic [7:0] b);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= int'(b)) r++;
        return 16'(int'(a) * int'(a) + r);
    endfunction

    // compute unit: answers a start seen at a falling edge unless told to ignore it
    initial forever begin
        @(negedge clk);
        if (!rst_i) begin
            busy_cnt = 0;
            busy     = force_busy;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) result = pending;
            end else if (start_o) begin
                if (model_ignore > 0) model_ignore--;
                else begin
                    busy_cnt = model_lat;
                    pending  = calc(a_bo, b_bo);
                    result   = 16'hDEAD;
                end
            end
            busy = force_busy || (busy_cnt > 0);
        end
    end

    // output monitor and scoreboard
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_i) begin
            if (int'(count_o) > max_count) max_count = int'(count_o);
            if (start_o) begin
                starts++;
                prev_start_cyc = last_start_cyc; prev_a = last_a; prev_b = last_b;
                last_start_cyc = cyc;            last_a = a_bo;   last_b = b_bo;
            end
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected: got %0d, required no output", out_result);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (out_result !== e) begin
                        errors++;
                        $display("FAIL scoreboard_result: got %0d, required %0d", out_result, e);
                    end
                end
            end
        end
    end

    task automatic expect_eq(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk); #1 out_ready = v;
    endtask

    task automatic set_force(input bit v);
        @(posedge clk); #1 force_busy = v;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        bit done = 0;
        bit acc;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b;
        for (int t = 0; t < 300 && !done; t++) begin
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(calc(a, b));
                done = 1;
            end else @(negedge clk);
        end
        #1 in_valid = 1'b0;
        if (!done) begin
            vectors++; errors++;
            $display("FAIL push_timeout: got no acceptance, required in_ready within 300 cycles");
        end
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1;
        end
        if (!done) begin
            vectors++; errors++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        expect_eq("reset_in_ready", int'(in_ready), 1);
        expect_eq("reset_out_valid", int'(out_valid), 0);
        expect_eq("reset_start", int'(start_o), 0);
        expect_eq("reset_count", int'(count_o), 0);
    endtask

    task automatic test_single();
        int s0, v0;
        set_ready(1); model_lat = 20;
        s0 = starts; v0 = valid_cycles;
        push(8'd3, 8'd27);
        @(posedge clk); @(negedge clk);
        expect_eq("single_start_latency", int'(start_o), 1);
        expect_eq("single_a_bo", int'(a_bo), 3);
        expect_eq("single_b_bo", int'(b_bo), 27);
        wait_drain();
        expect_eq("single_start_pulses", starts - s0, 1);
        expect_eq("single_valid_cycles", valid_cycles - v0, 1);
        expect_eq("single_result_reg", int'(out_result), 12);
    endtask

    task automatic test_back_to_back();
        int s0;
        logic [7:0] av[5] = '{8'd1, 8'd2, 8'd10, 8'd255, 8'd0};
        logic [7:0] bv[5] = '{8'd1, 8'd64, 8'd125, 8'd255, 8'd7};
        set_ready(0); model_lat = 3;
        s0 = starts;
        for (int i = 0; i < 5; i++) push(av[i], bv[i]);
        repeat (30) @(negedge clk);
        expect_eq("fill_count_full", int'(count_o), 4);
        expect_eq("fill_in_ready", int'(in_ready), 0);
        expect_eq("fill_out_valid_held", int'(out_valid), 1);
        expect_eq("fill_result_held", int'(out_result), int'(calc(8'd1, 8'd1)));
        expect_eq("fill_single_start", starts - s0, 1);
        set_ready(1);
        wait_drain();
        expect_eq("fill_total_starts", starts - s0, 5);
    endtask

    task automatic test_full_wrap();
        set_ready(1); model_lat = 2; max_count = 0;
        for (int i = 0; i < 10; i++) push(8'(i * 23 + 1), 8'(i * 29));
        wait_drain();
        expect_eq("wrap_max_count", max_count, 4);
        expect_eq("wrap_count_empty", int'(count_o), 0);
    endtask

    task automatic test_busy_hold();
        int s0;
        set_force(1); model_lat = 4;
        s0 = starts;
        push(8'd200, 8'd125);
        repeat (10) @(negedge clk);
        expect_eq("busy_hold_no_start", starts - s0, 0);
        set_force(0);
        @(posedge clk); @(negedge clk);
        expect_eq("busy_release_start", int'(start_o), 1);
        wait_drain();
    endtask

    task automatic test_retry();
        int s0;
        model_ignore = 1; model_lat = 5;
        s0 = starts;
        push(8'd100, 8'd8);
        wait_drain();
        expect_eq("retry_pulses", starts - s0, 2);
        expect_eq("retry_gap", last_start_cyc - prev_start_cyc, 5);
        expect_eq("retry_first_a", int'(prev_a), 100);
        expect_eq("retry_second_a", int'(last_a), 100);
        expect_eq("retry_second_b", int'(last_b), 8);
        expect_eq("retry_count_once", int'(count_o), 0);
    endtask

    task automatic test_reset_mid();
        int s0;
        set_ready(1); model_lat = 20;
        push(8'd5, 8'd1); push(8'd6, 8'd8); push(8'd7, 8'd27);
        repeat (8) @(negedge clk);
        expect_eq("mid_busy_before_reset", int'(busy), 1);
        #2 rst_i = 1'b0;
        #1;
        expect_eq("mid_reset_start", int'(start_o), 0);
        expect_eq("mid_reset_out_valid", int'(out_valid), 0);
        expect_eq("mid_reset_out_result", int'(out_result), 0);
        expect_eq("mid_reset_a_bo", int'(a_bo), 0);
        expect_eq("mid_reset_b_bo", int'(b_bo), 0);
        expect_eq("mid_reset_count", int'(count_o), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #3 rst_i = 1'b1;
        s0 = starts;
        repeat (30) @(negedge clk);
        expect_eq("mid_no_replay", starts - s0, 0);
        expect_eq("mid_out_idle", int'(out_valid), 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_wrap();
        test_busy_hold();
        test_retry();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
